// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// Memory op codes, access sizes, FSM states, lane-mask helpers.
package mem_stage_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        logic [7:0] m;
        unique case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic misaligned(
        input logic [2:0] off,
        input logic [1:0] size
    );
        logic r;
        unique case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = off[0];
            SZ_W:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_lane_align.sv
// Byte-lane alignment for the memory stage.
// Store shift/mask and load extract with sign/zero extension.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    input  logic [63:0] st_data,
    input  logic [63:0] ld_raw,
    output logic [63:0] wdata,
    output logic [7:0]  wmask,
    output logic [63:0] ld_data
);

    logic [1:0]  size;
    logic        uns;
    logic [63:0] ld_shift;

    assign size = funct3[1:0];
    assign uns  = funct3[2];

    // Lanes past byte 7 fall off the top of the shifts.
    always_comb begin
        wmask    = lane_mask(size) << off;
        wdata    = st_data << {off, 3'b000};
        ld_shift = ld_raw >> {off, 3'b000};
        ld_data  = ld_shift;
        unique case (size)
            SZ_B: ld_data = uns ?
                {56'b0, ld_shift[7:0]} :
                {{56{ld_shift[7]}}, ld_shift[7:0]};
            SZ_H: ld_data = uns ?
                {48'b0, ld_shift[15:0]} :
                {{48{ld_shift[15]}}, ld_shift[15:0]};
            SZ_W: ld_data = uns ?
                {32'b0, ld_shift[31:0]} :
                {{32{ld_shift[31]}}, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: one load/store per beat over dmem.
// Optional MEM_MISALIGN_CHK_EN flags misaligned accesses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int DMEM_AW = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [DMEM_AW-1:0] in_ram_addr,
    input  logic [XLEN-1:0]    in_src2,
    input  logic [1:0]         in_mem_op,
    input  logic [2:0]         in_funct3,
    input  logic [4:0]         in_rd,
    input  logic               in_rf_wen,
    output logic               dmem_req_valid,
    input  logic               dmem_req_ready,
    output logic               dmem_req_we,
    output logic [DMEM_AW-1:0] dmem_req_addr,
    output logic [XLEN-1:0]    dmem_req_wdata,
    output logic [7:0]         dmem_req_wmask,
    input  logic               dmem_resp_valid,
    input  logic [XLEN-1:0]    dmem_resp_rdata,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic               wb_wen,
    output logic [XLEN-1:0]    wb_data,
    output logic               misalign_err
);

    logic [1:0]         state;
    logic               r_store;
    logic [DMEM_AW-1:0] r_addr;
    logic [XLEN-1:0]    r_src2;
    logic [XLEN-1:0]    r_alu;
    logic [2:0]         r_funct3;
    logic [4:0]         r_rd;
    logic               r_wen;

    logic               accept;
    logic               is_mem;
    logic               misal;
    logic               req_on;
    logic [XLEN-1:0]    st_wdata;
    logic [7:0]         st_wmask;
    logic [XLEN-1:0]    ld_data;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mem   = (in_mem_op == MEM_LOAD) |
                      (in_mem_op == MEM_STORE);

`ifdef MEM_MISALIGN_CHK_EN
    logic err_q;

    assign misal = is_mem &
        misaligned(in_ram_addr[2:0], in_funct3[1:0]);

    // One-cycle error pulse alongside the suppressed writeback.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= accept & misal;
    end

    assign misalign_err = err_q;
`else
    assign misal        = 1'b0;
    assign misalign_err = 1'b0;
`endif

    mem_lane_align u_align (
        .off     (r_addr[2:0]),
        .funct3  (r_funct3),
        .st_data (r_src2),
        .ld_raw  (dmem_resp_rdata),
        .wdata   (st_wdata),
        .wmask   (st_wmask),
        .ld_data (ld_data)
    );

    // Request fields come straight from the latched beat while in REQ.
    assign req_on         = (state == ST_REQ);
    assign dmem_req_valid = req_on;
    assign dmem_req_we    = req_on & r_store;
    assign dmem_req_addr  = req_on ?
        {r_addr[DMEM_AW-1:3], 3'b000} : '0;
    assign dmem_req_wdata = (req_on & r_store) ? st_wdata : '0;
    assign dmem_req_wmask = (req_on & r_store) ? st_wmask : '0;

    // Sequencer: IDLE -> REQ -> (RESP) -> IDLE with writeback pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            r_store  <= 1'b0;
            r_addr   <= '0;
            r_src2   <= '0;
            r_alu    <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_wen    <= 1'b0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_wen   <= 1'b0;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_mem || misal) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= in_rd;
                            wb_data  <= in_alu_result;
                            wb_wen   <= ~misal & in_rf_wen &
                                        (in_rd != 5'd0);
                        end else begin
                            state    <= ST_REQ;
                            r_store  <= (in_mem_op == MEM_STORE);
                            r_addr   <= in_ram_addr;
                            r_src2   <= in_src2;
                            r_alu    <= in_alu_result;
                            r_funct3 <= in_funct3;
                            r_rd     <= in_rd;
                            r_wen    <= in_rf_wen;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        if (r_store) begin
                            state    <= ST_IDLE;
                            wb_valid <= 1'b1;
                            wb_rd    <= r_rd;
                            wb_data  <= r_alu;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (dmem_resp_valid) begin
                        state    <= ST_IDLE;
                        wb_valid <= 1'b1;
                        wb_rd    <= r_rd;
                        wb_data  <= ld_data;
                        wb_wen   <= r_wen & (r_rd != 5'd0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// Random and directed beats checked against a byte-level model.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu_result;
    logic [63:0] in_ram_addr;
    logic [63:0] in_src2;
    logic [1:0]  in_mem_op;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_rf_wen;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [63:0] dmem_req_addr;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_wmask;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [63:0] wb_data;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_alu_result   (in_alu_result),
        .in_ram_addr     (in_ram_addr),
        .in_src2         (in_src2),
        .in_mem_op       (in_mem_op),
        .in_funct3       (in_funct3),
        .in_rd           (in_rd),
        .in_rf_wen       (in_rf_wen),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wmask  (dmem_req_wmask),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_wen          (wb_wen),
        .wb_data         (wb_data),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- reference model: byte-by-byte view of the access ----
    function automatic int m_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010, 3'b110: return 4;
            default:        return 8;
        endcase
    endfunction

    function automatic logic [7:0] m_wmask(
        input logic [63:0] a, input logic [2:0] f3);
        logic [7:0] m = 8'h00;
        int off = int'(a[2:0]);
        for (int i = 0; i < m_bytes(f3); i++)
            if (off + i < 8) m[off + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] m_load(
        input logic [63:0] a, input logic [2:0] f3,
        input logic [63:0] rd_data);
        logic [63:0] v = 64'h0;
        int off = int'(a[2:0]);
        int n = m_bytes(f3);
        for (int i = 0; i < n; i++)
            if (off + i < 8)
                v[8*i +: 8] = rd_data[8*(off+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
        return v;
    endfunction

    function automatic logic m_misal(
        input logic [63:0] a, input logic [2:0] f3);
        return (int'(a[2:0]) % m_bytes(f3)) != 0;
    endfunction

    // ---- stimulus: present one beat, return at the next negedge ----
    task automatic send(input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] s2, input logic [63:0] alu,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic wen);
        in_valid      = 1'b1;
        in_mem_op     = op;
        in_ram_addr   = a;
        in_src2       = s2;
        in_alu_result = alu;
        in_funct3     = f3;
        in_rd         = rd;
        in_rf_wen     = wen;
        @(negedge clk);
        in_valid  = 1'b0;
        in_mem_op = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, dmem_req_valid, dmem_req_we, dmem_req_addr,
             dmem_req_wdata, dmem_req_wmask} !== {1'b1, 1'b0, 1'b0,
             64'h0, 64'h0, 8'h0}) begin
            n_fail++;
            $display("FAIL reset_req: rdy=%b v=%b we=%b a=%h d=%h m=%h want 1 0 0 0 0 0",
                in_ready, dmem_req_valid, dmem_req_we, dmem_req_addr,
                dmem_req_wdata, dmem_req_wmask);
        end
        n_checks++;
        if ({wb_valid, wb_wen, wb_rd, wb_data, misalign_err} !==
            {1'b0, 1'b0, 5'd0, 64'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_wb: v=%b wen=%b rd=%0d d=%h err=%b want all 0",
                wb_valid, wb_wen, wb_rd, wb_data, misalign_err);
        end
    endtask

    task automatic test_none();
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  op;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                alu = 64'h1234; rd = 5'd5; wen = 1'b1; op = 2'b00;
            end else begin
                alu = {$urandom, $urandom};
                rd  = (i == 1) ? 5'd0 : 5'($urandom);
                wen = (i == 1) ? 1'b1 : 1'($urandom);
                op  = $urandom_range(0, 1) ? 2'b11 : 2'b00;
            end
            send(op, {$urandom, $urandom}, {$urandom, $urandom},
                 alu, 3'($urandom), rd, wen);
            n_checks++;
            if ({wb_valid, wb_data, wb_rd, wb_wen, dmem_req_valid,
                 in_ready, misalign_err} !== {1'b1, alu, rd,
                 wen && rd != 5'd0, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL none_%0d: v=%b d=%h rd=%0d wen=%b req=%b rdy=%b want 1 %h %0d %b 0 1",
                    i, wb_valid, wb_data, wb_rd, wb_wen, dmem_req_valid,
                    in_ready, alu, rd, wen && rd != 5'd0);
            end
            @(negedge clk);
            n_checks++;
            if (wb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL none_pulse_%0d: wb_valid=%b want 0", i, wb_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] alu [8];
        logic [4:0]  rd  [8];
        logic        wen [8];
        for (int k = 0; k < 8; k++) begin
            alu[k] = {$urandom, $urandom};
            rd[k]  = 5'($urandom);
            wen[k] = 1'($urandom);
        end
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                n_checks++;
                if ({wb_valid, wb_data, wb_rd, wb_wen, in_ready} !==
                    {1'b1, alu[k-1], rd[k-1],
                     wen[k-1] && rd[k-1] != 5'd0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: v=%b d=%h rd=%0d wen=%b rdy=%b want data %h",
                        k, wb_valid, wb_data, wb_rd, wb_wen, in_ready,
                        alu[k-1]);
                end
            end
            in_valid      = (k < 8);
            in_mem_op     = 2'b00;
            in_alu_result = alu[k % 8];
            in_rd         = rd[k % 8];
            in_rf_wen     = wen[k % 8];
            @(negedge clk);
        end
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: wb_valid=%b want 0", wb_valid);
        end
    endtask

    task automatic test_store();
        logic [63:0] a, d, alu, ew;
        logic [7:0]  em;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int st;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) begin
                a = 64'h1003; d = 64'hAB; f3 = 3'b000;
                st = 0; rd = 5'd7;
            end else begin
                a  = {$urandom, $urandom};
                d  = {$urandom, $urandom};
                f3 = ($urandom_range(0, 4) == 4) ? 3'b111 :
                     3'($urandom_range(0, 3));
                st = $urandom_range(0, 3);
                rd = 5'($urandom);
`ifdef MEM_MISALIGN_CHK_EN
                a[2:0] = a[2:0] & ~3'(m_bytes(f3) - 1);
`endif
            end
            alu = {$urandom, $urandom};
            ew  = d << (8 * int'(a[2:0]));
            em  = m_wmask(a, f3);
            send(2'b10, a, d, alu, f3, rd, 1'b1);
            for (int k = 0; k <= st; k++) begin
                n_checks++;
                if ({dmem_req_valid, dmem_req_we, dmem_req_addr,
                     dmem_req_wdata, dmem_req_wmask, in_ready,
                     wb_valid} !== {1'b1, 1'b1, a[63:3], 3'b000, ew,
                     em, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL store_req_%0d_%0d: v=%b we=%b a=%h d=%h m=%h rdy=%b wbv=%b want a=%h d=%h m=%h",
                        i, k, dmem_req_valid, dmem_req_we, dmem_req_addr,
                        dmem_req_wdata, dmem_req_wmask, in_ready, wb_valid,
                        {a[63:3], 3'b000}, ew, em);
                end
                dmem_req_ready = (k == st);
                @(negedge clk);
            end
            dmem_req_ready = 1'b0;
            n_checks++;
            if ({wb_valid, wb_wen, wb_rd, dmem_req_valid, in_ready} !==
                {1'b1, 1'b0, rd, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL store_wb_%0d: v=%b wen=%b rd=%0d req=%b rdy=%b want 1 0 %0d 0 1",
                    i, wb_valid, wb_wen, wb_rd, dmem_req_valid, in_ready, rd);
            end
        end
    endtask

    task automatic test_load();
        logic [63:0] a, rdat, ev;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        wen;
        int st, rs;
        for (int i = 0; i < 20; i++) begin
            rd = 5'($urandom_range(1, 31)); wen = 1'b1;
            if (i < 2) begin
                a = 64'h2006; rdat = 64'h0080_0000_0000_0000;
                f3 = (i == 0) ? 3'b000 : 3'b100; st = 3; rs = 0;
            end else if (i == 2) begin
                a = 64'h2004; rdat = 64'h8000_0000_1111_1111;
                f3 = 3'b010; st = 0; rs = 0;
            end else begin
                a    = {$urandom, $urandom};
                rdat = {$urandom, $urandom};
                f3   = 3'($urandom);
                st   = $urandom_range(0, 3);
                rs   = $urandom_range(0, 3);
                rd   = 5'($urandom);
                wen  = 1'($urandom);
`ifdef MEM_MISALIGN_CHK_EN
                a[2:0] = a[2:0] & ~3'(m_bytes(f3) - 1);
`endif
            end
            ev = m_load(a, f3, rdat);
            send(2'b01, a, {$urandom, $urandom}, {$urandom, $urandom},
                 f3, rd, wen);
            for (int k = 0; k <= st; k++) begin
                n_checks++;
                if ({dmem_req_valid, dmem_req_we, dmem_req_addr,
                     in_ready, wb_valid} !== {1'b1, 1'b0, a[63:3],
                     3'b000, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL load_req_%0d_%0d: v=%b we=%b a=%h rdy=%b wbv=%b want 1 0 %h 0 0",
                        i, k, dmem_req_valid, dmem_req_we, dmem_req_addr,
                        in_ready, wb_valid, {a[63:3], 3'b000});
                end
                dmem_req_ready = (k == st);
                @(negedge clk);
            end
            dmem_req_ready = 1'b0;
            for (int k = 0; k <= rs; k++) begin
                n_checks++;
                if ({dmem_req_valid, in_ready, wb_valid} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL load_wait_%0d_%0d: req=%b rdy=%b wbv=%b want 0 0 0",
                        i, k, dmem_req_valid, in_ready, wb_valid);
                end
                dmem_resp_valid = (k == rs);
                dmem_resp_rdata = (k == rs) ? rdat : {$urandom, $urandom};
                @(negedge clk);
            end
            dmem_resp_valid = 1'b0;
            n_checks++;
            if ({wb_valid, wb_data, wb_rd, wb_wen, in_ready} !==
                {1'b1, ev, rd, wen && rd != 5'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL load_wb_%0d: v=%b d=%h rd=%0d wen=%b rdy=%b want d=%h rd=%0d wen=%b",
                    i, wb_valid, wb_data, wb_rd, wb_wen, in_ready, ev, rd,
                    wen && rd != 5'd0);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        send(2'b01, 64'h4000, 64'h0, 64'h55, 3'b011, 5'd3, 1'b1);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({in_ready, dmem_req_valid, dmem_req_we, dmem_req_addr,
                 dmem_req_wdata, dmem_req_wmask, wb_valid, wb_wen, wb_rd,
                 wb_data, misalign_err} !== {1'b1, 1'b0, 1'b0, 64'h0,
                 64'h0, 8'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0}) begin
                n_fail++;
                $display("FAIL rst_mid_%0d: rdy=%b req=%b wbv=%b wen=%b rd=%0d d=%h err=%b want idle/zero",
                    k, in_ready, dmem_req_valid, wb_valid, wb_wen, wb_rd,
                    wb_data, misalign_err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_misalign();
        logic [63:0] a [2];
        logic [2:0]  f3 [2];
        logic [1:0]  op [2];
        a[0] = 64'h3004; f3[0] = 3'b011; op[0] = 2'b01;
        a[1] = 64'h1006; f3[1] = 3'b010; op[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (m_misal(a[i], f3[i]) !== 1'b1) begin
                n_fail++;
                $display("FAIL mis_model_%0d: model says aligned", i);
            end
            send(op[i], a[i], 64'h1122_3344_5566_7788, 64'h0, f3[i],
                 5'd9, 1'b1);
`ifdef MEM_MISALIGN_CHK_EN
            n_checks++;
            if ({dmem_req_valid, misalign_err, wb_valid, wb_wen,
                 in_ready} !== 5'b01101) begin
                n_fail++;
                $display("FAIL mis_%0d: req=%b err=%b wbv=%b wen=%b rdy=%b want 0 1 1 0 1",
                    i, dmem_req_valid, misalign_err, wb_valid, wb_wen,
                    in_ready);
            end
            @(negedge clk);
            n_checks++;
            if ({dmem_req_valid, misalign_err, wb_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL mis_pulse_%0d: req=%b err=%b wbv=%b want 0 0 0",
                    i, dmem_req_valid, misalign_err, wb_valid);
            end
`else
            n_checks++;
            if ({dmem_req_valid, misalign_err, dmem_req_wmask} !==
                {1'b1, 1'b0, (i == 0) ? 8'h00 : 8'hC0}) begin
                n_fail++;
                $display("FAIL mis_nochk_%0d: req=%b err=%b m=%h want 1 0 %h",
                    i, dmem_req_valid, misalign_err, dmem_req_wmask,
                    (i == 0) ? 8'h00 : 8'hC0);
            end
            dmem_req_ready = 1'b1;
            @(negedge clk);
            dmem_req_ready = 1'b0;
            if (i == 0) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = 64'h8000_0000_1111_1111;
                @(negedge clk);
                dmem_resp_valid = 1'b0;
                n_checks++;
                if ({wb_valid, wb_data} !== {1'b1, 64'h8000_0000}) begin
                    n_fail++;
                    $display("FAIL mis_nochk_ld: v=%b d=%h want 1 0000000080000000",
                        wb_valid, wb_data);
                end
            end
`endif
        end
    endtask

    initial begin
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_alu_result   = '0;
        in_ram_addr     = '0;
        in_src2         = '0;
        in_mem_op       = '0;
        in_funct3       = '0;
        in_rd           = '0;
        in_rf_wen       = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = '0;
        @(negedge clk);
        test_reset();
        test_none();
        test_back_to_back();
        test_store();
        test_load();
        test_reset_mid_op();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
